// File: rtl/aes_core_serial_top.sv
// aes_core_serial_top
//   Column-serial AES-128 core (FIPS-197). A 32-bit column passes through
//   four shared S-boxes each cycle. Round keys are derived on the fly, so
//   only the current round key is stored.
//
//   Optional feature macro: AES_SERIAL_DECRYPT_EN
//     defined   : enc_dec selects encrypt (1) or decrypt (0).
//     undefined : inverse S-box, InvMixColumns and KEYPRE are absent.
//                 enc_dec is ignored and every operation encrypts.
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     start      request, sampled only while ready=1
//     enc_dec    1=encrypt, 0=decrypt, sampled with start
//     data_in    input block, byte 0 = bits [127:120]
//     key_in     AES-128 cipher key (original key for both directions)
//     data_out   registered result, same byte order as data_in
//     ready      1=idle (data_out valid or reset value), 0=busy
//     dbg_state  current FSM state (IDLE=0, KEYPRE=1, ROUND=2, DONE=3)
//
//   Handshake: a request is taken on an edge where ready=1 and start=1.
//   ready then stays 0 until the edge that publishes data_out. While ready=0,
//   start and every other input are ignored.
//
//   Latency (start edge = edge 0): ready rises at edge 52 for encrypt and at
//   edge 62 for decrypt.
//     edge 0        load. Encrypt also applies the initial AddRoundKey here.
//     edges 1-10    KEYPRE (decrypt only): forward expansion up to round key 10
//     next 50 edges ROUND: 10 rounds of 5 cycles
//     next 2 edges  DONE: the second DONE edge publishes data_out and ready
module aes_core_serial_top (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         enc_dec,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic [127:0] data_out,
  output logic         ready,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYPRE = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // GF(2^8) arithmetic
  // ---------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254. The addition chain is
  // 2, 3, 6, 12, 15, 30, 60, 120, 240, 252, 254. The inverse of 0 comes out as 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    return gmul(x252, x2);
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

`ifdef AES_SERIAL_DECRYPT_EN
  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  // One S-box lane. The GF inverse is shared between both directions and
  // only the affine step moves around it.
  function automatic logic [7:0] sbox(input logic [7:0] x, input logic inv);
    logic [7:0] g;
    g = ginv(inv ? inv_affine(x) : x);
    return inv ? g : affine(g);
  endfunction
`else
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return affine(ginv(x));
  endfunction
`endif

  // ---------------------------------------------------------------------
  // Block-level transforms. Byte k of a block is bits [127-8k -: 8], and
  // byte k sits in row k%4 and column k/4.
  // ---------------------------------------------------------------------
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
        o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * src) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127 - 32 * c -: 32] = mix_col(s[127 - 32 * c -: 32]);
    return o;
  endfunction

`ifdef AES_SERIAL_DECRYPT_EN
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127 - 32 * c -: 32] = inv_mix_col(s[127 - 32 * c -: 32]);
    return o;
  endfunction
`endif

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t       fsm, fsm_n;
  logic [2:0]   phase, phase_n;    // 0-3 column substitution, 4 round combine
  logic [3:0]   rnd, rnd_n;        // round (or KEYPRE step) number, 1..10
  logic [127:0] st, st_n;          // cipher state
  logic [127:0] rk, rk_n;          // current round key
  logic [127:0] dout_n;
`ifdef AES_SERIAL_DECRYPT_EN
  logic         dec, dec_n;        // operation in progress is a decrypt
`else
  logic         unused_enc_dec;
  assign unused_enc_dec = enc_dec;
`endif

  assign ready     = (fsm == IDLE);
  assign dbg_state = fsm;

  // ---------------------------------------------------------------------
  // Datapath: shared S-boxes, key step, round combine
  // ---------------------------------------------------------------------
  logic [31:0]  w0, w1, w2, w3, kw, col, sb_in, sb_out, t_word;
  logic [31:0]  n0, n1, n2, n3;
  logic [3:0]   rc_idx;
  logic [127:0] key_fwd, round_enc;
  logic         col_phase;
`ifdef AES_SERIAL_DECRYPT_EN
  logic         sb_inv;
  logic [127:0] key_bwd, round_dec;
`endif

  always_comb begin : datapath
    {w0, w1, w2, w3} = rk;
    col_phase = (fsm == ROUND) && (phase != 3'd4);
    case (phase[1:0])
      2'd0:    col = st[127:96];
      2'd1:    col = st[95:64];
      2'd2:    col = st[63:32];
      default: col = st[31:0];
    endcase

    // Key word that feeds SubWord(RotWord). Going backward, the previous
    // key's last word is w3^w2, and the Rcon index counts down from 10.
    kw     = w3;
    rc_idx = rnd;
`ifdef AES_SERIAL_DECRYPT_EN
    sb_inv = dec && col_phase;
    if (dec && fsm == ROUND) begin
      kw     = w3 ^ w2;
      rc_idx = 4'd11 - rnd;
    end
`endif

    // Substitution cycles take the state column. All other cycles lend the
    // S-boxes to the key schedule.
    sb_in = col_phase ? col : {kw[23:0], kw[31:24]};
    for (int i = 0; i < 4; i++) begin
`ifdef AES_SERIAL_DECRYPT_EN
      sb_out[31 - 8 * i -: 8] = sbox(sb_in[31 - 8 * i -: 8], sb_inv);
`else
      sb_out[31 - 8 * i -: 8] = sbox(sb_in[31 - 8 * i -: 8]);
`endif
    end
    t_word = sb_out ^ {rcon(rc_idx), 24'h000000};

    n0      = w0 ^ t_word;
    n1      = w1 ^ n0;
    n2      = w2 ^ n1;
    n3      = w3 ^ n2;
    key_fwd = {n0, n1, n2, n3};

    // SubBytes has already run column by column, and it commutes with
    // ShiftRows. The final round skips MixColumns.
    round_enc = shift_rows(st, 1'b0);
    if (rnd != 4'd10) round_enc = mix_cols(round_enc);
    round_enc = round_enc ^ key_fwd;

`ifdef AES_SERIAL_DECRYPT_EN
    key_bwd   = {w0 ^ t_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    round_dec = shift_rows(st, 1'b1) ^ key_bwd;
    if (rnd != 4'd10) round_dec = inv_mix_cols(round_dec);
`endif
  end

  // ---------------------------------------------------------------------
  // FSM: next state and next register values
  // ---------------------------------------------------------------------
  always_comb begin : next_state
    fsm_n   = fsm;
    phase_n = phase;
    rnd_n   = rnd;
    st_n    = st;
    rk_n    = rk;
    dout_n  = data_out;
`ifdef AES_SERIAL_DECRYPT_EN
    dec_n   = dec;
`endif
    case (fsm)
      IDLE: begin
        if (start) begin
          rk_n    = key_in;
          rnd_n   = 4'd1;
          phase_n = 3'd0;
`ifdef AES_SERIAL_DECRYPT_EN
          dec_n = ~enc_dec;
          if (!enc_dec) begin
            // The initial AddRoundKey needs round key 10, which is not yet known.
            st_n  = data_in;
            fsm_n = KEYPRE;
          end else begin
            st_n  = data_in ^ key_in;
            fsm_n = ROUND;
          end
`else
          st_n  = data_in ^ key_in;
          fsm_n = ROUND;
`endif
        end
      end
`ifdef AES_SERIAL_DECRYPT_EN
      KEYPRE: begin
        rk_n  = key_fwd;
        rnd_n = rnd + 4'd1;
        if (rnd == 4'd10) begin
          st_n    = st ^ key_fwd;
          rnd_n   = 4'd1;
          phase_n = 3'd0;
          fsm_n   = ROUND;
        end
      end
`endif
      ROUND: begin
        if (phase != 3'd4) begin
          case (phase[1:0])
            2'd0:    st_n[127:96] = sb_out;
            2'd1:    st_n[95:64]  = sb_out;
            2'd2:    st_n[63:32]  = sb_out;
            default: st_n[31:0]   = sb_out;
          endcase
          phase_n = phase + 3'd1;
        end else begin
          phase_n = 3'd0;
          rnd_n   = rnd + 4'd1;
`ifdef AES_SERIAL_DECRYPT_EN
          if (dec) begin
            st_n = round_dec;
            rk_n = key_bwd;
          end else
`endif
          begin
            st_n = round_enc;
            rk_n = key_fwd;
          end
          if (rnd == 4'd10) begin
            rnd_n = 4'd0;
            fsm_n = DONE;
          end
        end
      end
      DONE: begin
        // DONE spans two cycles, so completion lands on a fixed edge for
        // both directions. The second DONE edge publishes the result.
        if (phase == 3'd0) begin
          phase_n = 3'd1;
        end else begin
          dout_n  = st;
          phase_n = 3'd0;
          fsm_n   = IDLE;
        end
      end
      default: fsm_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm      <= IDLE;
      phase    <= 3'd0;
      rnd      <= 4'd0;
      st       <= '0;
      rk       <= '0;
      data_out <= '0;
`ifdef AES_SERIAL_DECRYPT_EN
      dec      <= 1'b0;
`endif
    end else begin
      fsm      <= fsm_n;
      phase    <= phase_n;
      rnd      <= rnd_n;
      st       <= st_n;
      rk       <= rk_n;
      data_out <= dout_n;
`ifdef AES_SERIAL_DECRYPT_EN
      dec      <= dec_n;
`endif
    end
  end

endmodule

// File: tb/tb_aes_core_serial_top.sv
// tb_aes_core_serial_top
//   Directed bench for aes_core_serial_top using FIPS-197 known-answer
//   vectors. An expected queue is filled when a request is driven and
//   drained when ready rises. Decrypt steps are included when
//   AES_SERIAL_DECRYPT_EN is defined. Otherwise the same requests with
//   enc_dec=0 must still encrypt with the 52-edge latency.
module tb_aes_core_serial_top;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         enc_dec;
  logic [127:0] data_in;
  logic [127:0] key_in;
  logic [127:0] data_out;
  logic         ready;
  logic [1:0]   dbg_state;

  aes_core_serial_top dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .enc_dec   (enc_dec),
    .data_in   (data_in),
    .key_in    (key_in),
    .data_out  (data_out),
    .ready     (ready),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int           checks = 0;
  int           errors = 0;
  logic [127:0] exp_q[$];
  logic [127:0] last_out = '0;

`ifdef AES_SERIAL_DECRYPT_EN
  localparam int LAT_DEC = 62;
`else
  localparam int LAT_DEC = 52;
`endif
  localparam int LAT_ENC = 52;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Driver: issue one request and follow it to completion.
  // exp_lat is the edge, counted from the start edge, on which ready must rise.
  // With pulse set, competing random requests are thrown at the busy core.
  task automatic do_op(input string tag, input logic enc, input logic [127:0] din,
                       input logic [127:0] key, input logic [127:0] exp,
                       input int exp_lat, input logic pulse);
    int         lat;
    logic [1:0] exp_st;
`ifdef AES_SERIAL_DECRYPT_EN
    exp_st = enc ? 2'd2 : 2'd1;
`else
    exp_st = 2'd2;
`endif
    start   = 1'b1;
    enc_dec = enc;
    data_in = din;
    key_in  = key;
    exp_q.push_back(exp);
    @(posedge clk);  // edge 0
    #1;
    start   = 1'b0;
    data_in = rnd128();
    key_in  = rnd128();
    enc_dec = 1'($urandom_range(0, 1));
    chk($sformatf("%s_busy", tag), 128'(ready), 128'(0));
    chk($sformatf("%s_state", tag), 128'(dbg_state), 128'(exp_st));
    chk($sformatf("%s_hold", tag), data_out, last_out);
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat = n;
        break;
      end
      if (pulse) begin
        start   = 1'($urandom_range(0, 1));
        enc_dec = 1'($urandom_range(0, 1));
        data_in = rnd128();
        key_in  = rnd128();
      end
    end
    start = 1'b0;
    chk($sformatf("%s_latency", tag), 128'(lat), 128'(exp_lat));
    if (exp_q.size() > 0) begin
      last_out = exp_q.pop_front();
      chk($sformatf("%s_data", tag), data_out, last_out);
    end
    if (pulse) begin
      // A start on the completion edge must not have launched anything.
      @(posedge clk);
      #1;
      chk($sformatf("%s_idle_after", tag), 128'(ready), 128'(1));
      chk($sformatf("%s_out_held", tag), data_out, last_out);
    end
  endtask

  // Directed sequence
  initial begin
    rst     = 1'b1;
    start   = 1'b1;  // reset must win over start
    enc_dec = 1'b1;
    data_in = PT_C1;
    key_in  = KEY_C1;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    chk("reset_ready", 128'(ready), 128'(1));
    chk("reset_data", data_out, 128'h0);
    chk("reset_state", 128'(dbg_state), 128'(0));

    do_op("c1_enc", 1'b1, PT_C1, KEY_C1, CT_C1, LAT_ENC, 1'b0);
`ifdef AES_SERIAL_DECRYPT_EN
    do_op("c1_dec", 1'b0, CT_C1, KEY_C1, PT_C1, LAT_DEC, 1'b0);
    do_op("b_enc", 1'b1, PT_B, KEY_B, CT_B, LAT_ENC, 1'b0);
    do_op("b_dec", 1'b0, CT_B, KEY_B, PT_B, LAT_DEC, 1'b0);
    do_op("zero_enc", 1'b1, 128'h0, 128'h0, CT_Z, LAT_ENC, 1'b0);
    do_op("zero_dec", 1'b0, CT_Z, 128'h0, 128'h0, LAT_DEC, 1'b0);
    do_op("busy_dec", 1'b0, CT_B, KEY_B, PT_B, LAT_DEC, 1'b1);
`else
    do_op("c1_encdec0", 1'b0, PT_C1, KEY_C1, CT_C1, LAT_DEC, 1'b0);
    do_op("b_enc", 1'b1, PT_B, KEY_B, CT_B, LAT_ENC, 1'b0);
    do_op("b_encdec0", 1'b0, PT_B, KEY_B, CT_B, LAT_DEC, 1'b0);
    do_op("zero_enc", 1'b1, 128'h0, 128'h0, CT_Z, LAT_ENC, 1'b0);
    do_op("zero_encdec0", 1'b0, 128'h0, 128'h0, CT_Z, LAT_DEC, 1'b0);
`endif
    do_op("busy_enc", 1'b1, PT_C1, KEY_C1, CT_C1, LAT_ENC, 1'b1);

    // Abort an encrypt with reset on edge 20.
    start   = 1'b1;
    enc_dec = 1'b1;
    data_in = PT_B;
    key_in  = KEY_B;
    @(posedge clk);  // edge 0
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);  // edges 1..19
    #1;
    chk("abort_busy", 128'(ready), 128'(0));
    rst = 1'b1;
    @(posedge clk);  // edge 20
    #1;
    rst = 1'b0;
    chk("abort_ready", 128'(ready), 128'(1));
    chk("abort_data", data_out, 128'h0);
    last_out = '0;
    do_op("post_reset_enc", 1'b1, PT_C1, KEY_C1, CT_C1, LAT_ENC, 1'b0);

    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
